// File: rtl/hit_zone_overlay.sv
// Rectangular hit-zone overlay for the VGA colour path.
// Per-zone tier highlight with frame-aligned sensor snapshots and hold timers.
module hit_zone_overlay #(
    parameter int          NUM_ZONES     = 3,
    parameter int          BITS_PER_ZONE = 6,
    parameter int          TIER_SPAN     = 2,
    parameter int          HOLD_FRAMES   = 30,
    parameter int          CNT_W         = 16,
    parameter logic [23:0] COLOR_T0      = 24'h90EE90,
    parameter logic [23:0] COLOR_T1      = 24'h32CD32,
    parameter logic [23:0] COLOR_T2      = 24'h006400
) (
    input  logic                         iVGA_CLK,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [NUM_ZONES*BITS_PER_ZONE-1:0] sensor_n,
    input  logic                         overlay_en,
    input  logic                         hold_mode,
    input  logic                         cnt_clear,
    input  logic [NUM_ZONES*10-1:0]      zone_x0,
    input  logic [NUM_ZONES*10-1:0]      zone_x1,
    input  logic [NUM_ZONES*10-1:0]      zone_y0,
    input  logic [NUM_ZONES*10-1:0]      zone_y1,
    input  logic                         pix_valid,
    input  logic [9:0]                   pix_x,
    input  logic [9:0]                   pix_y,
    input  logic [23:0]                  bg_color,
    output logic                         out_valid,
    output logic [23:0]                  out_color,
    output logic [NUM_ZONES*CNT_W-1:0]   hit_count,
    output logic [NUM_ZONES-1:0]         hit_pulse
);

    localparam int NB = NUM_ZONES * BITS_PER_ZONE;
    localparam int BZ = BITS_PER_ZONE;
    localparam logic [7:0] HOLD_LD = 8'(HOLD_FRAMES);

    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] snap;

    logic [NUM_ZONES-1:0] new_act;
    logic [NUM_ZONES-1:0] zone_active;
    logic [NUM_ZONES-1:0] hit_ev;
    logic [NUM_ZONES-1:0] disp;
    logic [NUM_ZONES-1:0] inside_d;
    logic [NUM_ZONES-1:0] s1_inside;

    logic [NUM_ZONES-1:0][1:0]       new_tier;
    logic [NUM_ZONES-1:0][1:0]       cur_tier;
    logic [NUM_ZONES-1:0][1:0]       held_tier;
    logic [NUM_ZONES-1:0][7:0]       hold_timer;
    logic [NUM_ZONES-1:0][CNT_W-1:0] cnt;
    logic [NUM_ZONES-1:0][23:0]      zone_col;

    logic        s1_valid;
    logic [23:0] s1_bg;
    logic [23:0] pix_col;

    // Tier of the highest-index asserted (low) bit in a zone group.
    function automatic logic [1:0] tier_of(
        input logic [BZ-1:0] b
    );
        logic [1:0] t;
        t = 2'd0;
        for (int j = 0; j < BZ; j++) begin
            if (!b[j]) begin
                t = (j / TIER_SPAN >= 2) ? 2'd2
                                         : 2'(j / TIER_SPAN);
            end
        end
        return t;
    endfunction

    function automatic logic [23:0] tier_color(
        input logic [1:0] t
    );
        logic [23:0] c;
        unique case (t)
            2'd0:    c = COLOR_T0;
            2'd1:    c = COLOR_T1;
            default: c = COLOR_T2;
        endcase
        return c;
    endfunction

    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            snap  <= '1;
        end else begin
            sync1 <= sensor_n;
            sync2 <= sync1;
            if (frame_start) begin
                snap <= sync2;
            end
        end
    end

    always_comb begin
        new_act     = '0;
        zone_active = '0;
        new_tier    = '0;
        cur_tier    = '0;
        hit_ev      = '0;
        disp        = '0;
        zone_col    = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            new_act[z]     = ~&sync2[z*BZ +: BZ];
            zone_active[z] = ~&snap[z*BZ +: BZ];
            new_tier[z]    = tier_of(sync2[z*BZ +: BZ]);
            cur_tier[z]    = tier_of(snap[z*BZ +: BZ]);
            hit_ev[z]      = frame_start & new_act[z]
                           & ~zone_active[z];
            disp[z]        = zone_active[z]
                           | (hold_mode & (|hold_timer[z]));
            zone_col[z]    = tier_color(zone_active[z]
                                        ? cur_tier[z]
                                        : held_tier[z]);
        end
    end

    // A coincident clear drops the increment but not the pulse or timer load.
    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            hold_timer <= '0;
            held_tier  <= '0;
            cnt        <= '0;
            hit_pulse  <= '0;
        end else begin
            hit_pulse <= hit_ev;
            for (int z = 0; z < NUM_ZONES; z++) begin
                if (hit_ev[z]) begin
                    hold_timer[z] <= HOLD_LD;
                    held_tier[z]  <= new_tier[z];
                end else if (frame_start && hold_timer[z] != 8'd0) begin
                    hold_timer[z] <= hold_timer[z] - 8'd1;
                end
                if (cnt_clear) begin
                    cnt[z] <= '0;
                end else if (hit_ev[z] && cnt[z] != '1) begin
                    cnt[z] <= cnt[z] + CNT_W'(1);
                end
            end
        end
    end

    assign hit_count = cnt;

    always_comb begin
        inside_d = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            inside_d[z] = (zone_x0[z*10 +: 10] < pix_x)
                       && (pix_x < zone_x1[z*10 +: 10])
                       && (zone_y0[z*10 +: 10] < pix_y)
                       && (pix_y < zone_y1[z*10 +: 10]);
        end
    end

    // Walk downward so the lowest-index matching zone wins.
    always_comb begin
        pix_col = s1_bg;
        if (overlay_en) begin
            for (int z = NUM_ZONES - 1; z >= 0; z--) begin
                if (s1_inside[z] && disp[z]) begin
                    pix_col = zone_col[z];
                end
            end
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_inside <= '0;
            s1_bg     <= '0;
            out_valid <= 1'b0;
            out_color <= '0;
        end else begin
            s1_valid  <= pix_valid;
            s1_inside <= inside_d;
            s1_bg     <= bg_color;
            out_valid <= s1_valid;
            out_color <= s1_valid ? pix_col : 24'h0;
        end
    end

endmodule

// File: tb/tb_hit_zone_overlay.sv
// Scoreboard bench for hit_zone_overlay against a frame-level reference model.
module tb_hit_zone_overlay;

    localparam int NZ  = 3;
    localparam int BPZ = 6;
    localparam int TS  = 2;
    localparam int HF  = 3;
    localparam int CW  = 4;
    localparam int NB  = NZ * BPZ;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic [NB-1:0]     sensor_n;
    logic              overlay_en;
    logic              hold_mode;
    logic              cnt_clear;
    logic [NZ*10-1:0]  zx0, zx1, zy0, zy1;
    logic              pix_valid;
    logic [9:0]        pix_x, pix_y;
    logic [23:0]       bg;
    logic              out_valid;
    logic [23:0]       out_color;
    logic [NZ*CW-1:0]  hit_count;
    logic [NZ-1:0]     hit_pulse;

    always #5 clk = ~clk;

    hit_zone_overlay #(
        .NUM_ZONES(NZ), .BITS_PER_ZONE(BPZ), .TIER_SPAN(TS),
        .HOLD_FRAMES(HF), .CNT_W(CW)
    ) dut (
        .iVGA_CLK(clk), .reset(reset), .frame_start(frame_start),
        .sensor_n(sensor_n), .overlay_en(overlay_en),
        .hold_mode(hold_mode), .cnt_clear(cnt_clear),
        .zone_x0(zx0), .zone_x1(zx1), .zone_y0(zy0), .zone_y1(zy1),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .bg_color(bg), .out_valid(out_valid), .out_color(out_color),
        .hit_count(hit_count), .hit_pulse(hit_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];

    bit m_act[NZ];
    int m_tier[NZ];
    int m_held[NZ];
    int m_timer[NZ];
    int m_cnt[NZ];
    int bx0[NZ], bx1[NZ], by0[NZ], by1[NZ];

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pixel: got %0h expected none",
                         out_color);
            end else begin
                check("pixel", 64'(out_color), 64'(exp_q.pop_front()));
            end
        end else if (!reset) begin
            check("idle_color", 64'(out_color), 64'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] tcol(input int t);
        if (t == 0) return 24'h90EE90;
        if (t == 1) return 24'h32CD32;
        return 24'h006400;
    endfunction

    function automatic logic [23:0] model_pix(input int x, input int y,
                                              input logic [23:0] b);
        if (overlay_en !== 1'b1) return b;
        for (int z = 0; z < NZ; z++) begin
            if (bx0[z] < x && x < bx1[z] && by0[z] < y && y < by1[z]
                && (m_act[z] || (hold_mode === 1'b1 && m_timer[z] > 0)))
                return tcol(m_act[z] ? m_tier[z] : m_held[z]);
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int z = 0; z < NZ; z++) begin
            m_act[z] = 0; m_tier[z] = 0; m_held[z] = 0;
            m_timer[z] = 0; m_cnt[z] = 0;
        end
    endtask

    task automatic set_zone(input int z, input int a, input int b,
                            input int c, input int d);
        bx0[z] = a; bx1[z] = b; by0[z] = c; by1[z] = d;
        zx0[z*10 +: 10] = 10'(a);
        zx1[z*10 +: 10] = 10'(b);
        zy0[z*10 +: 10] = 10'(c);
        zy1[z*10 +: 10] = 10'(d);
    endtask

    task automatic send_pix(input int x, input int y, input logic [23:0] b);
        pix_x = 10'(x);
        pix_y = 10'(y);
        bg = b;
        pix_valid = 1'b1;
        exp_q.push_back(model_pix(x, y, b));
        tick();
    endtask

    task automatic drain();
        pix_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame(input logic [NB-1:0] s, input bit clr);
        bit ev[NZ];
        pix_valid = 1'b0;
        sensor_n = s;
        repeat (3) tick();
        frame_start = 1'b1;
        cnt_clear = clr;
        tick();
        frame_start = 1'b0;
        cnt_clear = 1'b0;
        for (int z = 0; z < NZ; z++) begin
            int hi;
            bit act;
            int tr;
            hi = -1;
            for (int j = 0; j < BPZ; j++)
                if (s[z*BPZ + j] == 1'b0) hi = j;
            act = (hi >= 0);
            tr = (hi < 0) ? 0 : ((hi / TS > 2) ? 2 : hi / TS);
            ev[z] = act && !m_act[z];
            if (ev[z]) begin
                m_timer[z] = HF;
                m_held[z] = tr;
            end else if (m_timer[z] > 0) begin
                m_timer[z]--;
            end
            if (clr) m_cnt[z] = 0;
            else if (ev[z] && m_cnt[z] < (1 << CW) - 1) m_cnt[z]++;
            m_act[z] = act;
            m_tier[z] = tr;
        end
        for (int z = 0; z < NZ; z++) begin
            check("hit_pulse", 64'(hit_pulse[z]), 64'(ev[z]));
            check("hit_count", 64'(hit_count[z*CW +: CW]), 64'(m_cnt[z]));
        end
        tick();
        check("pulse_width", 64'(hit_pulse), 64'(0));
    endtask

    function automatic logic [NB-1:0] zb(input int z, input int j);
        logic [NB-1:0] v;
        v = '1;
        v[z*BPZ + j] = 1'b0;
        return v;
    endfunction

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                tick();
            end else begin
                send_pix(int'($urandom_range(140, 300)),
                         int'($urandom_range(190, 310)), 24'($urandom));
            end
        end
        drain();
    endtask

    initial begin
        logic [NB-1:0] s;
        reset = 1'b1;
        frame_start = 1'b0;
        sensor_n = '1;
        overlay_en = 1'b1;
        hold_mode = 1'b0;
        cnt_clear = 1'b0;
        zx0 = '0; zx1 = '0; zy0 = '0; zy1 = '0;
        pix_valid = 1'b0;
        pix_x = '0; pix_y = '0; bg = '0;
        model_reset();
        for (int z = 0; z < NZ; z++) set_zone(z, 0, 0, 0, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_color", 64'(out_color), 64'(0));
        check("rst_hit_count", 64'(hit_count), 64'(0));
        check("rst_hit_pulse", 64'(hit_pulse), 64'(0));

        set_zone(0, 154, 193, 198, 247);
        set_zone(1, 170, 260, 210, 300);
        set_zone(2, 10, 11, 10, 100);
        send_pix(170, 220, 24'h123456);
        drain();
        frame(zb(0, 0), 1'b0);
        send_pix(170, 220, 24'h123456);
        drain();

        for (int k = 0; k < 5; k++) begin
            frame(zb(0, 4), 1'b0);
            send_pix(170, 220, 24'h123456);
            drain();
        end

        frame('1, 1'b0);
        hold_mode = 1'b1;
        frame(zb(0, 2), 1'b0);
        for (int k = 0; k < 5; k++) begin
            send_pix(170, 220, 24'hABCDEF);
            drain();
            frame('1, 1'b0);
        end
        hold_mode = 1'b0;
        frame(zb(0, 3), 1'b0);
        frame('1, 1'b0);
        send_pix(170, 220, 24'hABCDEF);
        drain();

        frame(zb(0, 1) & zb(1, 5), 1'b0);
        send_pix(154, 220, 24'h000111);
        send_pix(193, 220, 24'h000222);
        send_pix(170, 198, 24'h000333);
        send_pix(170, 247, 24'h000444);
        send_pix(155, 199, 24'h000555);
        send_pix(180, 230, 24'h000666);
        send_pix(250, 290, 24'h000777);
        send_pix(10, 50, 24'h000888);
        drain();

        for (int k = 0; k < 20; k++) begin
            frame(zb(2, 0), 1'b0);
            frame('1, 1'b0);
        end
        frame(zb(2, 1), 1'b1);
        frame('1, 1'b0);

        for (int k = 0; k < 60; k++) begin
            s = '1;
            for (int z = 0; z < NZ; z++) begin
                case ($urandom_range(0, 2))
                    1: s[z*BPZ + int'($urandom_range(0, BPZ - 1))] = 1'b0;
                    2: s[z*BPZ +: BPZ] = 6'($urandom);
                    default: ;
                endcase
            end
            hold_mode = 1'($urandom);
            overlay_en = ($urandom_range(0, 7) != 0);
            begin
                int a, c;
                a = int'($urandom_range(140, 250));
                c = int'($urandom_range(190, 280));
                set_zone(2, a, a + int'($urandom_range(0, 60)),
                         c, c + int'($urandom_range(0, 40)));
            end
            if ($urandom_range(0, 15) == 0) begin
                cnt_clear = 1'b1;
                tick();
                cnt_clear = 1'b0;
                for (int z = 0; z < NZ; z++) m_cnt[z] = 0;
                check("clear_only", 64'(hit_count), 64'(0));
            end
            frame(s, $urandom_range(0, 9) == 0);
            rand_pixels(20);
        end

        hold_mode = 1'b1;
        overlay_en = 1'b1;
        frame(zb(0, 5), 1'b0);
        send_pix(170, 220, 24'h0A0B0C);
        send_pix(171, 221, 24'h0A0B0D);
        send_pix(172, 222, 24'h0A0B0E);
        reset = 1'b1;
        pix_valid = 1'b1;
        tick();
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_color", 64'(out_color), 64'(0));
        check("midrst_count", 64'(hit_count), 64'(0));
        check("midrst_pulse", 64'(hit_pulse), 64'(0));
        exp_q.delete();
        model_reset();
        pix_valid = 1'b0;
        sensor_n = '1;
        tick();
        reset = 1'b0;
        frame('1, 1'b0);
        send_pix(170, 220, 24'h0C0B0A);
        drain();

        repeat (4) tick();
        check("queue_drain", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
